// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   32-entry register file with write-through bypass and a busy-bit
//   scoreboard that blocks issue on RAW and WAW hazards.
//
//   Ports
//     clk, rst                    clock; synchronous active-high reset
//     WB__FU_RF_regwrite/rd_id    writeback enable and destination
//     WB__RF_data                 writeback data
//     ID__RF_rs1_id/rs2_id        source register selects
//     ID__RF_rs1_used/rs2_used    source is a real operand
//     ID__RF_issue                decode requests issue
//     ID__RF_issue_regwrite/rd_id issuing instruction's destination
//     ID__RF_flush                drop all pending writes
//     RF__ID_rs1_data/rs2_data    combinational read data (with bypass)
//     RF__ID_stall                combinational hazard stall
//     RF__ID_pending              registered count of busy registers
module regfile_scoreboard #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  WB__FU_RF_regwrite,
   input  logic [4:0]            WB__FU_RF_rd_id,
   input  logic [DATA_WIDTH-1:0] WB__RF_data,
   input  logic [4:0]            ID__RF_rs1_id,
   input  logic [4:0]            ID__RF_rs2_id,
   input  logic                  ID__RF_rs1_used,
   input  logic                  ID__RF_rs2_used,
   input  logic                  ID__RF_issue,
   input  logic                  ID__RF_issue_regwrite,
   input  logic [4:0]            ID__RF_issue_rd_id,
   input  logic                  ID__RF_flush,
   output logic [DATA_WIDTH-1:0] RF__ID_rs1_data,
   output logic [DATA_WIDTH-1:0] RF__ID_rs2_data,
   output logic                  RF__ID_stall,
   output logic [5:0]            RF__ID_pending
);

   logic [DATA_WIDTH-1:0] regs [32];
   logic [31:0]           busy;
   logic [31:0]           busy_eff;
   logic [31:0]           busy_next;
   logic [5:0]            pend_next;

   logic wb_hit;
   logic rs1_clear;
   logic rs2_clear;
   logic rd_clear;
   logic accept;

   // A writeback to x0 is no write at all: it neither bypasses nor clears.
   assign wb_hit = WB__FU_RF_regwrite && (WB__FU_RF_rd_id != 5'd0);

   // While reset is held the visible state is the cleared state, even
   // before the first reset edge has zeroed the flops.
   assign busy_eff = rst ? '0 : busy;

   // NOTE: every signal driven in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      RF__ID_rs1_data = '0;
      if (wb_hit && (WB__FU_RF_rd_id == ID__RF_rs1_id))
         RF__ID_rs1_data = WB__RF_data;
      else if (!rst && (ID__RF_rs1_id != 5'd0))
         RF__ID_rs1_data = regs[ID__RF_rs1_id];
   end

   always_comb begin
      RF__ID_rs2_data = '0;
      if (wb_hit && (WB__FU_RF_rd_id == ID__RF_rs2_id))
         RF__ID_rs2_data = WB__RF_data;
      else if (!rst && (ID__RF_rs2_id != 5'd0))
         RF__ID_rs2_data = regs[ID__RF_rs2_id];
   end

   // A register being written back this cycle is already resolved, which
   // lets the dependent instruction issue alongside its producer's WB.
   assign rs1_clear = !ID__RF_rs1_used || (ID__RF_rs1_id == 5'd0) ||
                      !busy_eff[ID__RF_rs1_id] ||
                      (wb_hit && (WB__FU_RF_rd_id == ID__RF_rs1_id));
   assign rs2_clear = !ID__RF_rs2_used || (ID__RF_rs2_id == 5'd0) ||
                      !busy_eff[ID__RF_rs2_id] ||
                      (wb_hit && (WB__FU_RF_rd_id == ID__RF_rs2_id));
   assign rd_clear  = !ID__RF_issue_regwrite || (ID__RF_issue_rd_id == 5'd0) ||
                      !busy_eff[ID__RF_issue_rd_id] ||
                      (wb_hit && (WB__FU_RF_rd_id == ID__RF_issue_rd_id));

   assign RF__ID_stall = ID__RF_issue && !ID__RF_flush &&
                         !(rs1_clear && rs2_clear && rd_clear);
   assign accept       = ID__RF_issue && !ID__RF_flush && !RF__ID_stall;

   // Order matters: clear, then set (set wins on collision), then flush
   // (flush overrides everything).
   always_comb begin
      busy_next = busy_eff;
      if (wb_hit)
         busy_next[WB__FU_RF_rd_id] = 1'b0;
      if (accept && ID__RF_issue_regwrite && (ID__RF_issue_rd_id != 5'd0))
         busy_next[ID__RF_issue_rd_id] = 1'b1;
      if (ID__RF_flush)
         busy_next = '0;
      busy_next[0] = 1'b0;
   end

   always_comb begin
      pend_next = '0;
      for (int i = 1; i < 32; i++)
         pend_next = pend_next + 6'(busy_next[i]);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the register array is reset explicitly because the block
         // must read back zero after reset; this costs a reset on each entry.
         for (int i = 0; i < 32; i++)
            regs[i] <= '0;
         busy           <= '0;
         RF__ID_pending <= '0;
      end else begin
         if (wb_hit)
            regs[WB__FU_RF_rd_id] <= WB__RF_data;
         busy           <= busy_next;
         RF__ID_pending <= pend_next;
      end
   end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning register and data-port width.
REQ-002 The block SHALL have these ports, one per line: name  direction  width  meaning.
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- WB__FU_RF_regwrite  input  1  writeback write enable
- WB__FU_RF_rd_id  input  5  writeback destination register
- WB__RF_data  input  DATA_WIDTH  writeback data
- ID__RF_rs1_id  input  5  source register 1
- ID__RF_rs2_id  input  5  source register 2
- ID__RF_rs1_used  input  1  rs1 is a real operand
- ID__RF_rs2_used  input  1  rs2 is a real operand
- ID__RF_issue  input  1  decode requests issue of current instruction
- ID__RF_issue_regwrite  input  1  issuing instruction writes a register
- ID__RF_issue_rd_id  input  5  issuing instruction destination
- ID__RF_flush  input  1  pipeline flush; drop all pending writes
- RF__ID_rs1_data  output  DATA_WIDTH  source 1 read data
- RF__ID_rs2_data  output  DATA_WIDTH  source 2 read data
- RF__ID_stall  output  1  issue blocked by hazard
- RF__ID_pending  output  6  count of registers with a pending write

Function
REQ-003 Storage SHALL be 32 registers of DATA_WIDTH; register 0 SHALL read as 0, ignore writes, and never be busy.
REQ-004 Writes SHALL occur at the rising edge when WB__FU_RF_regwrite=1 and WB__FU_RF_rd_id!=0.
REQ-005 Reads SHALL be combinational; zero-cycle latency from rsN_id to rsN_data.
REQ-006 Write-through bypass: when WB__FU_RF_regwrite=1, rd_id==rsN_id, and rsN_id!=0, rsN_data SHALL equal WB__RF_data in that same cycle.
REQ-007 One busy bit per register (1..31) SHALL track instructions issued but not yet written back.
REQ-008 A source N is clear when rsN_used=0, rsN_id=0, busy[rsN_id]=0, or a qualifying WB write to rsN_id occurs this cycle.
REQ-009 A destination is clear when issue_regwrite=0, issue_rd_id=0, busy[issue_rd_id]=0, or a qualifying WB write to issue_rd_id occurs this cycle (WAW check).
REQ-010 RF__ID_stall SHALL be 1 iff ID__RF_issue=1, ID__RF_flush=0, and any of rs1, rs2, or the destination is not clear; the output is combinational.
REQ-011 Issue is accepted iff ID__RF_issue=1, RF__ID_stall=0, and ID__RF_flush=0.
REQ-012 An accepted issue with issue_regwrite=1 and rd!=0 SHALL set busy[rd] at the next edge.
REQ-013 A qualifying WB write SHALL clear busy[rd] at the next edge.
REQ-014 If a set and a clear hit the same register in the same cycle, set SHALL win and the bit remains 1.
REQ-015 ID__RF_flush=1 SHALL clear all busy bits at the next edge, overriding any issue set.
REQ-016 Register contents SHALL NOT be affected by flush; a WB write in the flush cycle still updates the register file.
REQ-017 RF__ID_pending SHALL be a registered value equal to the population count of busy bits after each edge; range 0..31, no wrap.
REQ-018 Writeback to a register that is not busy SHALL update data only; busy state and count are unchanged.

Reset
REQ-019 When rst=1 at an edge, all registers, all busy bits, and RF__ID_pending SHALL become 0.
REQ-020 Reset SHALL take priority over write, issue, and flush in the same cycle.
REQ-021 While rst is asserted, read outputs SHALL reflect the zeroed array plus bypass.
REQ-022 RF__ID_stall SHALL follow REQ-010 against the cleared state.

Verification
REQ-023 Write/read: WB writes x5=0xDEADBEEF; next cycle rs1_id=5 -> rs1_data=0xDEADBEEF; rs2_id=0 -> 0.
REQ-024 Bypass: in the same cycle WB writes x7=0x12345678 and rs2_id=7 -> rs2_data=0x12345678 with no delay.
REQ-025 RAW stall: issue rd=3 accepted (pending=1); next cycle issue with rs1_id=3, rs1_used=1 -> stall=1; a cycle with WB x3 -> stall=0, pending returns to 0.
REQ-026 Set/clear collision: busy[4]=1; in one cycle WB writes x4 and a new issue with rd=4 is accepted -> busy[4] stays 1, pending unchanged.
REQ-027 Flush: three registers busy (pending=3); flush=1 with a simultaneous issue rd=9 -> pending=0, x9 not busy, no stall.
REQ-028 Reset mid-operation: pending=2 and x1=0xA5 -> rst one cycle -> pending=0, x1 reads 0, stall=0.
